// File: rtl/btn_step_gen.sv
// Debounced push-button to single-cycle step pulses with optional hold-to-repeat.
// Press step is registered DEB_CYCLES+3 edges after btn_in rises; there is no backpressure.
module btn_step_gen #(
    parameter int TMR_W      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic rpt_en,
    output logic step,
    output logic btn_level,
    output logic rpt_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_HELD_WAIT,
        S_HELD_RPT,
        S_DEB_RELEASE
    } state_t;

    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(RPT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(RPT_PERIOD - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [TMR_W-1:0] r_tmr;
    logic             r_step;
    logic             r_level;
    logic             r_rpt;

    logic             w_btn_sync;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_step_nxt;
    logic             w_level_nxt;
    logic             w_rpt_nxt;

    assign w_btn_sync = r_sync2;
    assign step       = r_step;
    assign btn_level  = r_level;
    assign rpt_active = r_rpt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_step  <= 1'b0;
            r_level <= 1'b0;
            r_rpt   <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_step  <= w_step_nxt;
            r_level <= w_level_nxt;
            r_rpt   <= w_rpt_nxt;
        end
    end

    // Button changes are tested before timer expiry so they always win.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_step_nxt  = 1'b0;
        w_level_nxt = r_level;
        w_rpt_nxt   = r_rpt;
        unique case (r_state)
            S_IDLE: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_DEB_PRESS;
                    w_tmr_nxt   = '0;
                end
            end
            S_DEB_PRESS: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == DEB_LAST) begin
                    w_state_nxt = S_HELD_WAIT;
                    w_tmr_nxt   = '0;
                    w_step_nxt  = 1'b1;
                    w_level_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_HELD_WAIT: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_DEB_RELEASE;
                    w_tmr_nxt   = '0;
                end else if (rpt_en && (r_tmr == DLY_LAST)) begin
                    w_state_nxt = S_HELD_RPT;
                    w_tmr_nxt   = '0;
                    w_step_nxt  = 1'b1;
                    w_rpt_nxt   = 1'b1;
                end else if (rpt_en) begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_HELD_RPT: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_DEB_RELEASE;
                    w_tmr_nxt   = '0;
                    w_rpt_nxt   = 1'b0;
                end else if (!rpt_en) begin
                    w_state_nxt = S_HELD_WAIT;
                    w_tmr_nxt   = '0;
                    w_rpt_nxt   = 1'b0;
                end else if (r_tmr == PER_LAST) begin
                    w_tmr_nxt  = '0;
                    w_step_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_DEB_RELEASE: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_HELD_WAIT;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == DEB_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_step_gen.sv
// Directed bench for btn_step_gen with default parameters; edge 1 is the first edge sampling btn_in high.
module tb_btn_step_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic rpt_en = 1'b0;
    logic step;
    logic btn_level;
    logic rpt_active;

    btn_step_gen dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .rpt_en     (rpt_en),
        .step       (step),
        .btn_level  (btn_level),
        .rpt_active (rpt_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi_len;
        bit rpt;
        int rpt_off;
        int n;
        int edges [10];
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    int total = 0;
    int bad   = 0;
    int ecnt;
    int step_q [$];
    int dbl;
    logic prev_step, prev_lvl, prev_rpt;
    int lvl_rise, lvl_fall, rpt_rise, rpt_fall;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_trk();
        ecnt = 0;
        step_q.delete();
        dbl = 0;
        prev_step = step;
        prev_lvl  = btn_level;
        prev_rpt  = rpt_active;
        lvl_rise = -1; lvl_fall = -1; rpt_rise = -1; rpt_fall = -1;
    endtask

    task automatic tick(input logic b, input logic r);
        btn_in = b;
        rpt_en = r;
        @(posedge clk);
        ecnt++;
        #1;
        if (step) begin
            step_q.push_back(ecnt);
            if (prev_step) dbl++;
        end
        if (btn_level && !prev_lvl && lvl_rise < 0) lvl_rise = ecnt;
        if (!btn_level && prev_lvl && lvl_fall < 0) lvl_fall = ecnt;
        if (rpt_active && !prev_rpt && rpt_rise < 0) rpt_rise = ecnt;
        if (!rpt_active && prev_rpt && rpt_fall < 0) rpt_fall = ecnt;
        prev_step = step;
        prev_lvl  = btn_level;
        prev_rpt  = rpt_active;
    endtask

    task automatic do_reset();
        btn_in = 1'b0;
        rpt_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick(1'b0, 1'b0);
        clear_trk();
    endtask

    function automatic logic rpt_val(input int v, input int e);
        return tbl[v].rpt && (tbl[v].rpt_off == 0 || e < tbl[v].rpt_off);
    endfunction

    function automatic int q_at(input int i);
        return (i < step_q.size()) ? step_q[i] : -1;
    endfunction

    initial begin
        tbl[0] = '{15,  1'b0, 0,   0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{16,  1'b0, 0,   0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[2] = '{17,  1'b0, 0,   1, '{19, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{40,  1'b0, 0,   1, '{19, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{202, 1'b1, 0,   9, '{19, 83, 99, 115, 131, 147, 163, 179, 195, 0}};
        tbl[5] = '{202, 1'b1, 120, 4, '{19, 83, 99, 115, 0, 0, 0, 0, 0, 0}};
        tbl[6] = '{100, 1'b1, 0,   3, '{19, 83, 99, 0, 0, 0, 0, 0, 0, 0}};

        // Reset holds every output low even with the button pressed.
        rst = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 chk("rst_outs", {29'd0, step, btn_level, rpt_active}, 0);
        end

        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int e = 0; e < tbl[v].hi_len; e++) tick(1'b1, rpt_val(v, ecnt + 1));
            for (int e = 0; e < 60; e++) tick(1'b0, rpt_val(v, ecnt + 1));
            chk($sformatf("v%0d_nsteps", v), step_q.size(), tbl[v].n);
            for (int i = 0; i < tbl[v].n; i++)
                chk($sformatf("v%0d_step%0d_edge", v, i), q_at(i), tbl[v].edges[i]);
            chk($sformatf("v%0d_level_end", v), int'(btn_level), 0);
            chk($sformatf("v%0d_rpt_end", v), int'(rpt_active), 0);
            chk($sformatf("v%0d_dbl_step", v), dbl, 0);
        end

        // Level timing on a clean 40-cycle press.
        do_reset();
        repeat (40) tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        chk("press_level_rise", lvl_rise, 19);
        chk("release_level_fall", lvl_fall, 59);

        // Bounce: 10 hi, 3 lo, 15 hi, 3 lo, 20 hi; final run starts at edge 32.
        do_reset();
        repeat (10) tick(1'b1, 1'b0);
        repeat (3)  tick(1'b0, 1'b0);
        repeat (15) tick(1'b1, 1'b0);
        repeat (3)  tick(1'b0, 1'b0);
        repeat (20) tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        chk("bounce_nsteps", step_q.size(), 1);
        chk("bounce_step_edge", q_at(0), 50);

        // Repeat disabled at edge 120 while still held.
        do_reset();
        for (int e = 1; e <= 202; e++) tick(1'b1, (e < 120) ? 1'b1 : 1'b0);
        chk("rpt_active_rise", rpt_rise, 83);
        chk("rpt_active_fall", rpt_fall, 120);
        chk("rpt_off_level_held", int'(btn_level), 1);
        repeat (40) tick(1'b0, 1'b0);

        // Reset pulse mid-hold, then fresh debounce with the button still down.
        do_reset();
        repeat (50) tick(1'b1, 1'b0);
        chk("hold_level_pre_rst", int'(btn_level), 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outs", {29'd0, step, btn_level, rpt_active}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_trk();
        repeat (40) tick(1'b1, 1'b0);
        chk("post_rst_nsteps", step_q.size(), 1);
        chk("post_rst_step_edge", q_at(0), 19);
        chk("post_rst_level_rise", lvl_rise, 19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
